// File: rtl/mux_pkg.sv
// Shared definitions for the 4-to-1 data mux and its select arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mux_pkg;

  localparam int N_IN  = 4;
  localparam int SEL_W = 2;

  // Arbiter FSM encoding
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Reset pointer: the scan starts at PTR_RST+1, so source 0 wins first
  localparam logic [SEL_W-1:0] PTR_RST = 2'b11;

endpackage

// File: rtl/rr_next_picker.sv
// Round-robin winner pick: first set Req bit scanning circularly from Ptr+1.
// Latency: purely combinational.
// Backpressure: none; Any=0 means no source is requesting.
// Ports: Req[3:0] requests, Ptr[1:0] last winner, Win[1:0] next winner, Any any request.
module rr_next_picker
  import mux_pkg::*;
(
  input  logic [N_IN-1:0]  Req,
  input  logic [SEL_W-1:0] Ptr,
  output logic [SEL_W-1:0] Win,
  output logic             Any
);

  logic [SEL_W-1:0] start;
  logic [N_IN-1:0]  rot;
  logic [SEL_W-1:0] ofs;

  always_comb begin
    start = Ptr + 2'd1;
    // Rotate so bit 0 of rot is the highest-priority source
    rot = '0;
    for (int i = 0; i < N_IN; i++) begin
      rot[i] = Req[start + SEL_W'(i)];
    end
    // Priority encode lowest set bit of the rotated vector
    ofs = '0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (rot[i]) ofs = SEL_W'(i);
    end
    // Un-rotate; 2-bit addition wraps mod 4
    Win = start + ofs;
    Any = |Req;
  end

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter driving the 4-to-1 mux select with one-hot Grant/Valid.
// Latency: Req seen at edge N gives Valid at edge N+1; one dead cycle between grants.
// Backpressure: grant held until Done or Req[Sel] drops (or hold timeout with ARB_TIMEOUT_EN).
// Ports: Clk, Reset_n (async active-low), Req[3:0], Done pulse in;
//        Sel[1:0], Grant[3:0], Valid, TimedOut out (all registered).
// Optional: define ARB_TIMEOUT_EN to force-release a grant after MAX_HOLD cycles.
module rr_sel_arbiter
  import mux_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [N_IN-1:0]  Req,
  input  logic             Done,
  output logic [SEL_W-1:0] Sel,
  output logic [N_IN-1:0]  Grant,
  output logic             Valid,
  output logic             TimedOut
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_IN-1:0]  grant_q, grant_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic [SEL_W-1:0] win;
  logic             any_req;
  logic             release_now;

  rr_next_picker u_picker (
    .Req (Req),
    .Ptr (ptr_q),
    .Win (win),
    .Any (any_req)
  );

  // Done and a withdrawn request collapse into one release
  assign release_now = Done | ~Req[sel_q];

`ifdef ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              timed_out_q, timed_out_d;
  logic              hold_expired;

  assign hold_expired = (hold_q == HOLD_W'(MAX_HOLD - 1));
  assign TimedOut     = timed_out_q;
`else
  logic unused_cfg;
  assign unused_cfg = (MAX_HOLD > 0) ^ (HOLD_W > 0);
  assign TimedOut   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
    hold_d      = hold_q;
    timed_out_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        grant_d = '0;
        if (any_req) begin
          sel_d   = win;
          grant_d = N_IN'(1) << win;
          valid_d = 1'b1;
          state_d = ST_BUSY;
`ifdef ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      ST_BUSY: begin
`ifdef ARB_TIMEOUT_EN
        if (hold_q != '1) hold_d = hold_q + 1'b1;
        if (release_now || hold_expired) begin
          timed_out_d = ~release_now;
`else
        if (release_now) begin
`endif
          // Sel is held through the dead cycle so it never moves under Valid
          valid_d = 1'b0;
          grant_d = '0;
          ptr_d   = sel_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      ptr_q   <= PTR_RST;
`ifdef ARB_TIMEOUT_EN
      hold_q      <= '0;
      timed_out_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
      hold_q      <= hold_d;
      timed_out_q <= timed_out_d;
`endif
    end
  end

  assign Sel   = sel_q;
  assign Grant = grant_q;
  assign Valid = valid_q;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Self-checking bench for rr_sel_arbiter: behavioural model plus directed literals.
// Latency: n/a.
// Backpressure: n/a.
module tb_rr_sel_arbiter;
  localparam int TB_MAX_HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       valid;
  logic       timed_out;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 0;

  // Model state: who owns the mux, last winner, cycles the grant has been shown
  bit   m_busy;
  int   m_ptr;
  int   m_hold;
  int   e_sel;
  logic [3:0] e_grant;
  bit   e_valid;
  bit   e_to;

  rr_sel_arbiter #(.MAX_HOLD(TB_MAX_HOLD), .HOLD_W(8)) dut (
    .Clk      (clk),
    .Reset_n  (rst_n),
    .Req      (req),
    .Done     (done),
    .Sel      (sel),
    .Grant    (grant),
    .Valid    (valid),
    .TimedOut (timed_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: circular scan from last winner, release on Done/withdraw/timeout
  always @(posedge clk or negedge rst_n) begin : model
    int win;
    bit rel;
    bit tmo;
    if (!rst_n) begin
      m_busy  <= 0;
      m_ptr   <= 3;
      m_hold  <= 0;
      e_sel   <= 0;
      e_grant <= 4'b0000;
      e_valid <= 0;
      e_to    <= 0;
    end else begin
      e_to <= 0;
      if (!m_busy) begin
        win = -1;
        for (int k = 1; k <= 4; k++) begin
          if (win < 0 && req[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
        end
        if (win >= 0) begin
          e_sel   <= win;
          e_grant <= 4'(1 << win);
          e_valid <= 1;
          m_busy  <= 1;
          m_hold  <= 1;
        end else begin
          e_valid <= 0;
          e_grant <= 4'b0000;
        end
      end else begin
        rel = done || !req[e_sel];
        tmo = 0;
`ifdef ARB_TIMEOUT_EN
        tmo = !rel && (m_hold == TB_MAX_HOLD);
`endif
        if (rel || tmo) begin
          m_ptr   <= e_sel;
          m_busy  <= 0;
          e_valid <= 0;
          e_grant <= 4'b0000;
          e_to    <= tmo;
        end else begin
          m_hold <= m_hold + 1;
        end
      end
    end
  end

  // Cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_sel",   32'(sel),       32'(e_sel));
      chk("cmp_grant", 32'(grant),     32'(e_grant));
      chk("cmp_valid", 32'(valid),     32'(e_valid));
      chk("cmp_tout",  32'(timed_out), 32'(e_to));
    end
  end

  // Apply inputs at a negedge and advance to the next negedge
  task automatic step(input logic [3:0] r, input logic d);
    req  = r;
    done = d;
    @(negedge clk);
  endtask

  initial begin
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    req   = 4'b0000;
    done  = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_sel",   32'(sel),       0);
    chk("rst_grant", 32'(grant),     0);
    chk("rst_valid", 32'(valid),     0);
    chk("rst_tout",  32'(timed_out), 0);
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1;

    // Single requester, Done after a few cycles
    step(4'b0000, 0);
    step(4'b0001, 0);
    chk("t1_sel", 32'(sel), 0);
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_valid", 32'(valid), 1);
    step(4'b0001, 0);
    step(4'b0001, 0);
    step(4'b0001, 1);
    chk("t1_rel_valid", 32'(valid), 0);
    chk("t1_rel_grant", 32'(grant), 0);
    chk("t1_rel_sel", 32'(sel), 0);
    step(4'b0011, 0);
    chk("t1_ptr_next", 32'(sel), 1);
    step(4'b0011, 1);

    // Fresh pointer, all requesting, Done held: rotation 0,1,2,3,0
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(4'b1111, 1);
      if (i % 2 == 0) begin
        chk("t2_valid", 32'(valid), 1);
        chk("t2_sel", 32'(sel), 32'(exp_order[i / 2]));
      end else begin
        chk("t2_gap", 32'(valid), 0);
      end
    end

    // Wrap-around from Ptr=2 with Req=0011
    step(4'b0100, 0);
    chk("t3_pre", 32'(sel), 2);
    step(4'b0100, 1);
    step(4'b0011, 0);
    chk("t3_wrap", 32'(sel), 0);
    step(4'b0011, 1);
    step(4'b0011, 0);
    chk("t3_next", 32'(sel), 1);
    step(4'b0011, 1);

    // Granted source withdraws, then withdraw coincident with Done
    step(4'b0100, 0);
    chk("t4_sel", 32'(sel), 2);
    step(4'b0011, 0);
    chk("t4_drop_valid", 32'(valid), 0);
    chk("t4_drop_grant", 32'(grant), 0);
    chk("t4_drop_sel", 32'(sel), 2);
    step(4'b0000, 0);
    step(4'b0100, 0);
    chk("t4_regrant", 32'(sel), 2);
    step(4'b0000, 1);
    chk("t4_both_valid", 32'(valid), 0);
    step(4'b1100, 0);
    chk("t4_single_rot", 32'(sel), 3);

    // Async reset between edges while busy
    step(4'b1100, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_sel", 32'(sel), 0);
    chk("t5_grant", 32'(grant), 0);
    chk("t5_valid", 32'(valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1000, 0);
    chk("t5_sel3", 32'(sel), 3);
    chk("t5_grant3", 32'(grant), 32'h8);
    step(4'b1000, 1);

    // Long hold with no Done
    step(4'b0100, 0);
    chk("t6_sel", 32'(sel), 2);
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < TB_MAX_HOLD - 1; i++) begin
      step(4'b0100, 0);
      chk("t6_hold_valid", 32'(valid), 1);
    end
    step(4'b0100, 0);
    chk("t6_to_valid", 32'(valid), 0);
    chk("t6_to_pulse", 32'(timed_out), 1);
    step(4'b0100, 0);
    chk("t6_to_clear", 32'(timed_out), 0);
    chk("t6_regrant", 32'(valid), 1);
`else
    for (int i = 0; i < 50; i++) step(4'b0100, 0);
    chk("t6_still_valid", 32'(valid), 1);
    chk("t6_no_tout", 32'(timed_out), 0);
`endif
    step(4'b0000, 1);
    step(4'b0000, 0);

    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_sel_arbiter.md
Name: rr_sel_arbiter

Overview:
- Round-robin arbiter and sequencer for the 4-to-1 data mux.
- Sits directly upstream of the mux and drives its 2-bit Sel.
- Four sources request the shared mux output. The block grants one source at a time, holds the select stable for the transfer, then rotates priority.
- Out-of-band handshake: per-source Req, a consumer Done pulse, a one-hot Grant and a Valid qualifier.

Parameters:
- MAX_HOLD, default 16: cycle limit for one grant. Used only when ARB_TIMEOUT_EN is defined; legal range 2..255.
- HOLD_W, default 8: width of the hold counter. Must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset_n  input  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- Req  input  4  per-source request; bit i is the request from mux input In<i>. Level-sensitive.
- Done  input  1  single-cycle pulse from the consumer: current transfer complete.
- Sel  output  2  registered mux select, wired to the mux Sel.
- Grant  output  4  registered one-hot grant; all zero when idle.
- Valid  output  1  registered; high while Sel/Grant address a granted source.
- TimedOut  output  1  single-cycle pulse when a grant is force-released. Constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - Sel=2'b00, Grant=4'b0000, Valid=0, TimedOut=0.
  - Priority pointer Ptr=2'b11, so source 0 has the highest priority first. FSM=IDLE, hold counter=0.
- FSM states: IDLE, BUSY. State is registered; all outputs are registered, with no combinational path from Req/Done to outputs.
- IDLE, Req==0: remain in IDLE; outputs unchanged except Valid=0 and Grant=0. Sel keeps its last value.
- IDLE, Req!=0: winner W is the first set bit scanning circularly from Ptr+1 upward (mod 4).
  - Next edge: Sel=W, Grant=1<<W, Valid=1, state BUSY, counter=0.
  - Latency: Req seen at edge N gives Valid at edge N+1.
- BUSY: Sel and Grant are held constant. The counter increments each cycle, saturating at 2^HOLD_W-1.
- Release conditions in BUSY: Done==1, or Req[Sel]==0 (requester withdrew). On release, next edge:
  - Valid=0, Grant=0, Ptr=Sel, state IDLE.
  - Sel is held, so one dead cycle separates grants and the mux select never changes while Valid=1.
- Done and Req[Sel] drop in the same cycle: a single release, no double rotation.
- Done while IDLE: ignored.
- Other Req bits changing during BUSY: no effect until the next IDLE arbitration.
- Single requester re-requesting: regranted after the one dead cycle. There is no starvation because Ptr rotates past each winner.
- Maximum grant rate: one grant per 2 cycles (BUSY min 1 cycle + IDLE 1 cycle).
- Reset asserted mid-BUSY: immediate clear to reset values. The in-flight transfer is abandoned and no Done is required.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined: in BUSY, if counter==MAX_HOLD-1 and no other release condition holds, force release on the next edge (same effects as a normal release) and pulse TimedOut=1 for exactly one cycle. Done arriving in the same cycle takes precedence, and then TimedOut=0.
- Undefined:
  - No hold counter is implemented.
  - A grant persists until Done or Req drop.
  - TimedOut is tied to 0.
  - MAX_HOLD and HOLD_W are unused.

Decomposition:
- Shared package mux_pkg holds:
  - N_IN=4 and SEL_W=2.
  - State encoding constants ST_IDLE=1'b0 and ST_BUSY=1'b1.
  - The reset pointer constant PTR_RST=2'b11.
  - This package is shared with the mux and future datapath muxes.
- One natural sub-module: rr_next_picker. It is purely combinational: inputs Req[3:0] and Ptr[1:0], outputs Win[1:0] and Any. It performs the rotate, priority encode and un-rotate, and is unit-testable on its own.

Test Plan:
- Reset then Req=4'b0001 at cycle 2: Sel=0, Grant=0001, Valid=1 at cycle 3. Done pulse at cycle 6: Valid=0 at cycle 7, Ptr=0.
- Req=4'b1111 held, Done pulsed each BUSY cycle: grant order Sel=0,1,2,3,0 with Valid low one cycle between each grant.
- Ptr=2, Req=4'b0011: winner Sel=0 (wrap-around), then Sel=1 on the next grant.
- Granted source 2 drops Req[2] with no Done: release next edge, Valid=0. Done in the same cycle as the Req drop gives exactly one release.
- Reset_n pulled low mid-BUSY, asynchronously between edges: Sel=0, Grant=0, Valid=0 immediately. After release, Req=4'b1000 is granted Sel=3.
- With ARB_TIMEOUT_EN, MAX_HOLD=4, Req=4'b0100 held, no Done: Valid high 4 cycles, then TimedOut=1 for one cycle coincident with Valid=0. Without the macro, Valid stays high for 50 cycles.
